// File: rtl/div_seq.sv
`default_nettype none
// ============================================================================
//  Module   : div_seq
//  Purpose  : Multi-cycle sequencer for the RV32M divide class (DIV, DIVU,
//             REM, REMU) sitting in EX. Stalls the pipeline while a radix-2
//             restoring divider produces one quotient bit per cycle, then
//             presents the result for a single cycle. Divide-by-zero and
//             signed overflow take a one-cycle fast path.
//  Ports    : clk, rst (async, active-high)
//             start_i  - EX holds a valid divide-class instruction
//             op_i     - 00 DIV, 01 DIVU, 10 REM, 11 REMU
//             a_i/b_i  - dividend / divisor
//             flush_i  - EX instruction squashed
//             busy_o   - sequencer not idle
//             stall_o  - freeze IF/ID/EX, bubble into MEM
//             done_o   - result_o valid this cycle (one-cycle pulse)
//             result_o - quotient or remainder
//  Revision : 1.0 - initial release
// ============================================================================
module div_seq #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              flush_i,
  output logic              busy_o,
  output logic              stall_o,
  output logic              done_o,
  output logic [DATA_W-1:0] result_o
);

  localparam logic [1:0]        c_st_idle  = 2'd0;
  localparam logic [1:0]        c_st_calc  = 2'd1;
  localparam logic [1:0]        c_st_done  = 2'd2;
  localparam logic [CNT_W-1:0]  c_last_cnt = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] c_int_min  = {1'b1, {(DATA_W-1){1'b0}}};

  logic [1:0]        state_q,   state_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic              rem_sel_q, rem_sel_d;   // 1: REM/REMU, 0: DIV/DIVU
  logic              q_neg_q,   q_neg_d;     // negate quotient at the end
  logic              r_neg_q,   r_neg_d;     // remainder follows dividend sign
  logic [DATA_W-1:0] rem_q,     rem_d;
  logic [DATA_W-1:0] quo_q,     quo_d;       // dividend shifts out, quotient shifts in
  logic [DATA_W-1:0] babs_q,    babs_d;
  logic [DATA_W-1:0] result_q,  result_d;

  // Operand preparation for the start cycle
  logic              w_signed, w_a_neg, w_b_neg, w_ovf;
  logic [DATA_W-1:0] w_a_abs, w_b_abs;

  // One restoring iteration
  logic [DATA_W:0]   w_shifted, w_trial;
  logic [DATA_W-1:0] w_rem_step, w_quo_step, w_rem_fix, w_quo_fix;

  always_comb begin
    w_signed = ~op_i[0];
    w_a_neg  = w_signed & a_i[DATA_W-1];
    w_b_neg  = w_signed & b_i[DATA_W-1];
    w_a_abs  = w_a_neg ? (~a_i + 1'b1) : a_i;
    w_b_abs  = w_b_neg ? (~b_i + 1'b1) : b_i;
    w_ovf    = w_signed && (a_i == c_int_min) && (b_i == '1);

    // Partial remainder is always below |b|, so the shifted value fits in
    // DATA_W+1 bits and the trial's top bit is a reliable borrow flag.
    w_shifted  = {rem_q, quo_q[DATA_W-1]};
    w_trial    = w_shifted - {1'b0, babs_q};
    w_rem_step = w_trial[DATA_W] ? w_shifted[DATA_W-1:0] : w_trial[DATA_W-1:0];
    w_quo_step = {quo_q[DATA_W-2:0], ~w_trial[DATA_W]};
    w_quo_fix  = q_neg_q ? (~w_quo_step + 1'b1) : w_quo_step;
    w_rem_fix  = r_neg_q ? (~w_rem_step + 1'b1) : w_rem_step;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= c_st_idle;
      cnt_q     <= '0;
      rem_sel_q <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      babs_q    <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_sel_q <= rem_sel_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      babs_q    <= babs_d;
      result_q  <= result_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_sel_d = rem_sel_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    babs_d    = babs_q;
    result_d  = result_q;

    case (state_q)
      c_st_idle: begin
        if (start_i && !flush_i) begin
          rem_sel_d = op_i[1];
          q_neg_d   = w_a_neg ^ w_b_neg;
          r_neg_d   = w_a_neg;
          babs_d    = w_b_abs;
          cnt_d     = '0;
          if (b_i == '0) begin
            result_d = op_i[1] ? a_i : '1;
            state_d  = c_st_done;
          end else if (w_ovf) begin
            result_d = op_i[1] ? '0 : c_int_min;
            state_d  = c_st_done;
          end else begin
            rem_d   = '0;
            quo_d   = w_a_abs;
            state_d = c_st_calc;
          end
        end
      end
      c_st_calc: begin
        if (flush_i) begin
          state_d = c_st_idle;
        end else begin
          rem_d = w_rem_step;
          quo_d = w_quo_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == c_last_cnt) begin
            result_d = rem_sel_q ? w_rem_fix : w_quo_fix;
            state_d  = c_st_done;
          end
        end
      end
      c_st_done: begin
        // start_i here is the same instruction leaving EX, so it is ignored
        state_d = c_st_idle;
      end
      default: begin
        state_d = c_st_idle;
      end
    endcase
  end

  // Outputs
  always_comb begin
    busy_o   = (state_q != c_st_idle);
    done_o   = (state_q == c_st_done) && !flush_i;
    result_o = result_q;
    case (state_q)
      c_st_idle: stall_o = start_i && !flush_i;
      c_st_calc: stall_o = !flush_i;
      default:   stall_o = 1'b0;
    endcase
    if (rst) begin
      stall_o = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div_seq
//  Purpose  : Self-checking bench for div_seq. A driver issues divide
//             requests and pushes the expected result and latency into a
//             scoreboard; a monitor pops and compares on every done_o.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        flush_i = 1'b0;
  logic        busy_o, stall_o, done_o;
  logic [31:0] result_o;

  div_seq #(.DATA_W(32), .CNT_W(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .flush_i  (flush_i),
    .busy_o   (busy_o),
    .stall_o  (stall_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          scyc;
  } exp_t;

  exp_t        sbq[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] last_result = '0;
  bit          chk_idle = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference model: plain integer arithmetic with the RISC-V corner rules.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return op[1] ? (a % b) : (a / b);
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (chk_idle) begin
        chk("busy_after_done", {31'b0, busy_o}, 32'd0);
        chk_idle = 0;
      end
      if (done_o) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("result", result_o, e.res);
          chk("latency", 32'(cyc - e.scyc), 32'(e.lat));
          last_result = e.res;
          chk_idle = 1;
        end
      end
    end
  end

  // Issue one request and hold start_i until done_o, including the done cycle.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit scramble);
    exp_t e;
    bit   got;
    @(negedge clk);
    op_i = op; a_i = a; b_i = b; start_i = 1'b1;
    e.res = ref_div(op, a, b);
    e.lat = ref_lat(op, a, b);
    e.scyc = cyc;
    sbq.push_back(e);
    #1 chk("stall_start", {31'b0, stall_o}, 32'd1);
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk);
      #1;
      if (scramble) begin
        a_i = $urandom; b_i = $urandom; op_i = 2'($urandom);
      end
      @(negedge clk);
      if (done_o) begin
        chk("stall_at_done", {31'b0, stall_o}, 32'd0);
        got = 1;
      end else begin
        chk("stall_busy", {31'b0, stall_o}, 32'd1);
      end
    end
    if (!got) chk("timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [1:0]  rop;

    // Reset with start_i asserted: stall must stay low while rst is high
    start_i = 1'b1; a_i = 32'd50; b_i = 32'd5; op_i = 2'b01;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall",  {31'b0, stall_o}, 32'd0);
    chk("rst_busy",   {31'b0, busy_o},  32'd0);
    chk("rst_done",   {31'b0, done_o},  32'd0);
    chk("rst_result", result_o,         32'd0);
    @(negedge clk);
    rst = 1'b0; start_i = 1'b0;
    repeat (2) @(negedge clk);

    // Directed cases
    run_op(2'b00, 32'd100,        32'd7,         0);
    run_op(2'b10, 32'hFFFF_FFF9,  32'd2,         0);
    run_op(2'b00, 32'hFFFF_FFF9,  32'd2,         0);
    run_op(2'b01, 32'd5,          32'd0,         0);
    run_op(2'b11, 32'd5,          32'd0,         0);
    run_op(2'b00, 32'h8000_0000,  32'hFFFF_FFFF, 0);
    run_op(2'b10, 32'h8000_0000,  32'hFFFF_FFFF, 0);

    // Flush at cycle 10 of a DIVU
    @(negedge clk);
    op_i = 2'b01; a_i = 32'd1000; b_i = 32'd7; start_i = 1'b1;
    repeat (10) @(negedge clk);
    flush_i = 1'b1;
    #1;
    chk("stall_flush", {31'b0, stall_o}, 32'd0);
    chk("done_flush",  {31'b0, done_o},  32'd0);
    @(posedge clk);
    #1;
    chk("busy_after_flush", {31'b0, busy_o}, 32'd0);
    chk("result_kept",      result_o,        last_result);
    flush_i = 1'b0; start_i = 1'b0;
    repeat (40) @(negedge clk);

    // Flush together with start in IDLE: nothing starts
    @(negedge clk);
    op_i = 2'b01; a_i = 32'd10; b_i = 32'd2; start_i = 1'b1; flush_i = 1'b1;
    #1 chk("stall_idle_flush", {31'b0, stall_o}, 32'd0);
    @(posedge clk);
    #1 chk("busy_idle_flush", {31'b0, busy_o}, 32'd0);
    start_i = 1'b0; flush_i = 1'b0;
    repeat (3) @(negedge clk);

    // Reset pulse mid-CALC
    @(negedge clk);
    op_i = 2'b00; a_i = 32'd12345; b_i = 32'd67; start_i = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_stall",  {31'b0, stall_o}, 32'd0);
    chk("midrst_busy",   {31'b0, busy_o},  32'd0);
    chk("midrst_done",   {31'b0, done_o},  32'd0);
    chk("midrst_result", result_o,         32'd0);
    last_result = '0;
    @(negedge clk);
    rst = 1'b0; start_i = 1'b0;
    run_op(2'b01, 32'd9, 32'd3, 0);

    // Back-to-back; start_i stays high through the first done cycle
    run_op(2'b01, 32'd20, 32'd4, 0);
    run_op(2'b11, 32'd21, 32'd4, 0);

    // Randomized requests with operand scrambling after the start cycle
    for (int n = 0; n < 40; n++) begin
      rop = 2'($urandom);
      case ($urandom_range(0, 7))
        0:       ra = 32'h8000_0000;
        1:       ra = $urandom_range(0, 100);
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = $urandom_range(1, 15);
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb, 1);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
